// File: rtl/conv_mem_responder.sv
// ---------------------------------------------------------------------------
// conv_mem_responder
//
// Memory-side responder for the CONV engine. Holds the input image and the
// five layer banks, serves the engine's image read port and the layer
// read/write port with zero-latency reads, and runs the ready/busy start
// handshake. A host port preloads the image while idle and dumps any layer
// bank asynchronously.
//
// Ports
//   clk, reset              clock and synchronous active-high reset
//   start                   host pulse: begin a run (honoured in IDLE only)
//   img_we/img_addr/img_wdata  host image write (IDLE only)
//   dump_sel/dump_addr      host dump select/address -> dump_data (async)
//   ready (out) / busy (in) start handshake with the CONV engine
//   iaddr -> idata          image read, combinational
//   cwr/caddr_wr/cdata_wr   layer write, committed on posedge
//   crd/caddr_rd -> cdata_rd  layer read, combinational
//   csel                    bank select 1..5 = L0_K0, L0_K1, L1_K0, L1_K1, L2
//   done                    one-cycle pulse after busy falls in a run
//   err                     sticky protocol error, cleared by reset or start
//   wr_count                committed layer writes this run (saturating)
// ---------------------------------------------------------------------------
module conv_mem_responder #(
    parameter int DW      = 20,
    parameter int AW      = 12,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          img_we,
    input  logic [AW-1:0] img_addr,
    input  logic [DW-1:0] img_wdata,
    input  logic [2:0]    dump_sel,
    input  logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    output logic          done,
    output logic          err,
    output logic [15:0]   wr_count
);

    localparam int NB = 5;
    localparam int TW = $clog2(TIMEOUT + 1);

    // Address width of each bank: two full-size L0 banks, two quarter-size
    // L1 banks and one half-size L2 bank.
    function automatic int bank_aw(input int idx);
        case (idx)
            0, 1:    return AW;
            2, 3:    return AW - 2;
            default: return AW - 1;
        endcase
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic            ready_reg, ready_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;
    logic [15:0]     wr_count_reg, wr_count_next;
    logic [TW-1:0]   tmo_reg, tmo_next;

    // ---------------------------------------------------------------------
    // Image memory: host writes only while idle, engine reads combinationally
    // ---------------------------------------------------------------------
    logic [DW-1:0] img_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (img_we && state_reg == IDLE) begin
            img_mem[img_addr] <= img_wdata;
        end
    end

    assign idata = img_mem[iaddr];

    // ---------------------------------------------------------------------
    // Layer banks. Bank gi answers to csel == gi+1. A write is committed only
    // when every address bit above the bank's own width is zero, so a large
    // address never aliases onto a low word.
    // ---------------------------------------------------------------------
    logic [NB-1:0] wr_in_range;
    logic [NB-1:0] rd_in_range;
    logic [NB-1:0] dump_in_range;
    logic [NB-1:0] wr_en;
    logic [DW-1:0] rd_word   [NB];
    logic [DW-1:0] dump_word [NB];

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bank
            localparam int BAW = bank_aw(gi);

            logic [DW-1:0] mem [0:(1<<BAW)-1];

            assign wr_in_range[gi]   = (caddr_wr  >> BAW) == '0;
            assign rd_in_range[gi]   = (caddr_rd  >> BAW) == '0;
            assign dump_in_range[gi] = (dump_addr >> BAW) == '0;
            assign wr_en[gi]         = cwr && (csel == 3'(gi + 1)) && wr_in_range[gi];

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    mem[caddr_wr[BAW-1:0]] <= cdata_wr;
                end
            end

            assign rd_word[gi]   = mem[caddr_rd[BAW-1:0]];
            assign dump_word[gi] = mem[dump_addr[BAW-1:0]];
        end
    endgenerate

    // Read muxes: zero for a disabled read, an invalid select or an
    // out-of-range address.
    always_comb begin
        cdata_rd  = '0;
        dump_data = '0;
        for (int i = 0; i < NB; i++) begin
            if (crd && csel == 3'(i + 1) && rd_in_range[i]) begin
                cdata_rd = rd_word[i];
            end
            if (dump_sel == 3'(i + 1) && dump_in_range[i]) begin
                dump_data = dump_word[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Protocol error sources
    // ---------------------------------------------------------------------
    logic csel_valid;
    logic wr_commit;
    logic wr_drop;
    logic rd_sel_err;
    logic img_we_err;

    assign csel_valid = (csel >= 3'd1) && (csel <= 3'd5);
    assign wr_commit  = |wr_en;
    assign wr_drop    = cwr && !wr_commit;       // invalid select or out of range
    assign rd_sel_err = crd && !csel_valid;
    assign img_we_err = img_we && (state_reg != IDLE);

    // ---------------------------------------------------------------------
    // Handshake FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            ready_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            wr_count_reg <= '0;
            tmo_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            ready_reg    <= ready_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            wr_count_reg <= wr_count_next;
            tmo_reg      <= tmo_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ready_next    = ready_reg;
        done_next     = 1'b0;
        err_next      = err_reg;
        wr_count_next = wr_count_reg;
        tmo_next      = tmo_reg;

        case (state_reg)
            IDLE: begin
                ready_next = 1'b0;
                if (start) begin
                    state_next    = REQ;
                    ready_next    = 1'b1;
                    err_next      = 1'b0;
                    wr_count_next = '0;
                    tmo_next      = '0;
                end
            end
            REQ: begin
                // busy wins over a timeout landing in the same cycle
                if (busy) begin
                    state_next = RUN;
                    ready_next = 1'b0;
                end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
                    state_next = IDLE;
                    ready_next = 1'b0;
                    err_next   = 1'b1;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            RUN: begin
                if (!busy) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                ready_next = 1'b0;
            end
        endcase

        // Applied after the start clear so a write in the start cycle counts.
        if (wr_commit && wr_count_next != 16'hFFFF) begin
            wr_count_next = wr_count_next + 16'd1;
        end
        if (wr_drop || rd_sel_err || img_we_err) begin
            err_next = 1'b1;
        end
    end

    assign ready    = ready_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_conv_mem_responder.sv
module tb_conv_mem_responder;

    localparam int DW  = 20;
    localparam int AW  = 12;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          img_we = 1'b0;
    logic [AW-1:0] img_addr = '0;
    logic [DW-1:0] img_wdata = '0;
    logic [2:0]    dump_sel = '0;
    logic [AW-1:0] dump_addr = '0;
    logic [DW-1:0] dump_data;
    logic          ready;
    logic          busy = 1'b0;
    logic [AW-1:0] iaddr = '0;
    logic [DW-1:0] idata;
    logic          cwr = 1'b0;
    logic [AW-1:0] caddr_wr = '0;
    logic [DW-1:0] cdata_wr = '0;
    logic          crd = 1'b0;
    logic [AW-1:0] caddr_rd = '0;
    logic [DW-1:0] cdata_rd;
    logic [2:0]    csel = '0;
    logic          done;
    logic          err;
    logic [15:0]   wr_count;

    always #5 clk = ~clk;

    conv_mem_responder #(.DW(DW), .AW(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .img_we(img_we), .img_addr(img_addr), .img_wdata(img_wdata),
        .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data),
        .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel), .done(done), .err(err), .wr_count(wr_count)
    );

    int vec_cnt = 0;
    int miscompares = 0;

    // Reference model: plain arrays indexed by bank number and address.
    logic [DW-1:0] img_m  [4096];
    logic [DW-1:0] bank_m [5][4096];
    logic          err_m = 1'b0;
    int            cnt_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int depth(input logic [2:0] s);
        case (s)
            3'd1, 3'd2: return 4096;
            3'd3, 3'd4: return 1024;
            3'd5:       return 2048;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [2:0] s, input logic [AW-1:0] a);
        if (int'(a) < depth(s)) return bank_m[int'(s) - 1][a];
        return '0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Effect of the current inputs on the model for one cycle in RUN.
    task automatic model_step;
        if (cwr) begin
            if (int'(caddr_wr) < depth(csel)) begin
                bank_m[int'(csel) - 1][caddr_wr] = cdata_wr;
                if (cnt_m < 65535) cnt_m++;
            end else begin
                err_m = 1'b1;
            end
        end
        if (crd && depth(csel) == 0) err_m = 1'b1;
        if (img_we) err_m = 1'b1;
    endtask

    typedef struct {
        logic          wr;
        logic [2:0]    sel;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          rd;
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        logic [15:0]   exp_cnt;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int n;

        // Bank init pattern is {sel, 5'b0, addr}; expected reads below use it.
        vecs[0]  = '{1'b1, 3'd3, 12'h400, 20'hAAAAA, 1'b0, 12'h000, 20'h00000, 1'b1, 16'd1};
        vecs[1]  = '{1'b1, 3'd3, 12'h3FF, 20'h00007, 1'b1, 12'h400, 20'h00000, 1'b1, 16'd2};
        vecs[2]  = '{1'b1, 3'd5, 12'h7FF, 20'hBEEF5, 1'b1, 12'h7FF, 20'hA07FF, 1'b1, 16'd3};
        vecs[3]  = '{1'b0, 3'd5, 12'h000, 20'h00000, 1'b1, 12'h7FF, 20'hBEEF5, 1'b1, 16'd3};
        vecs[4]  = '{1'b1, 3'd1, 12'h000, 20'h12345, 1'b1, 12'h005, 20'h01234, 1'b1, 16'd4};
        vecs[5]  = '{1'b0, 3'd1, 12'h000, 20'h00000, 1'b0, 12'h000, 20'h00000, 1'b1, 16'd4};
        vecs[6]  = '{1'b0, 3'd0, 12'h000, 20'h00000, 1'b1, 12'h000, 20'h00000, 1'b1, 16'd4};
        vecs[7]  = '{1'b1, 3'd6, 12'h001, 20'h11111, 1'b0, 12'h000, 20'h00000, 1'b1, 16'd4};
        vecs[8]  = '{1'b1, 3'd2, 12'hFFF, 20'hFFFFF, 1'b1, 12'hFFF, 20'h40FFF, 1'b1, 16'd5};
        vecs[9]  = '{1'b1, 3'd4, 12'h3FF, 20'h00001, 1'b1, 12'h3FF, 20'h803FF, 1'b1, 16'd6};
        vecs[10] = '{1'b0, 3'd4, 12'h000, 20'h00000, 1'b1, 12'h3FF, 20'h00001, 1'b1, 16'd6};
        vecs[11] = '{1'b1, 3'd5, 12'h800, 20'h55555, 1'b1, 12'h800, 20'h00000, 1'b1, 16'd6};
        vecs[12] = '{1'b0, 3'd5, 12'h000, 20'h00000, 1'b1, 12'h000, 20'hA0000, 1'b1, 16'd6};
        vecs[13] = '{1'b0, 3'd3, 12'h000, 20'h00000, 1'b1, 12'h000, 20'h60000, 1'b1, 16'd6};

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_ready", ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_wr_count", wr_count, 16'd0);
        reset = 1'b0;

        // ---------------- fill all layer banks (IDLE) ----------------
        for (int s = 1; s <= 5; s++) begin
            for (int a = 0; a < depth(3'(s)); a++) begin
                cwr      = 1'b1;
                csel     = 3'(s);
                caddr_wr = 12'(a);
                cdata_wr = {3'(s), 5'b0, 12'(a)};
                bank_m[s - 1][a] = cdata_wr;
                tick();
            end
        end
        cwr = 1'b0;
        check("init_wr_count", wr_count, 16'd12288);
        check("init_err", err, 1'b0);

        // ---------------- image preload ----------------
        img_we = 1'b1;
        for (int a = 0; a < 4096; a++) begin
            img_addr  = 12'(a);
            img_wdata = 20'(a);
            img_m[a]  = 20'(a);
            tick();
        end
        img_we = 1'b0;
        check("load_err", err, 1'b0);
        $display("image loaded, banks filled");

        // ---------------- handshake into RUN ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        err_m = 1'b0;
        cnt_m = 0;
        check("req_ready", ready, 1'b1);
        check("start_clr_cnt", wr_count, 16'd0);
        busy = 1'b1;
        tick();
        check("run_ready", ready, 1'b0);
        check("run_done", done, 1'b0);
        $display("handshake: ready=%0b busy=%0b", ready, busy);

        // ---------------- zero-latency read and write-then-read ----------------
        iaddr = 12'h041;
        #1;
        check("idata_041", idata, 20'h00041);
        cwr = 1'b1; csel = 3'd1; caddr_wr = 12'd5; cdata_wr = 20'h01234;
        model_step();
        tick();
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd5;
        #1;
        check("wr_rd_l0k0", cdata_rd, 20'h01234);
        check("wr_count_1", wr_count, 16'd1);
        crd = 1'b0;
        $display("write-then-read L0_K0[5]=%0h", cdata_rd);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 14; i++) begin
            cwr = vecs[i].wr; csel = vecs[i].sel; caddr_wr = vecs[i].waddr;
            cdata_wr = vecs[i].wdata; crd = vecs[i].rd; caddr_rd = vecs[i].raddr;
            #1;
            check($sformatf("vec%0d_rd", i), cdata_rd, vecs[i].exp_rd);
            model_step();
            tick();
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            check($sformatf("vec%0d_cnt", i), wr_count, vecs[i].exp_cnt);
            $display("vec %0d: wr=%0b sel=%0d wa=%0h rd=%0b ra=%0h -> rd=%0h err=%0b cnt=%0d",
                     i, vecs[i].wr, vecs[i].sel, vecs[i].waddr, vecs[i].rd, vecs[i].raddr,
                     cdata_rd, err, wr_count);
        end
        cwr = 1'b0; crd = 1'b0;

        // ---------------- dump port ----------------
        dump_sel = 3'd3; dump_addr = 12'h3FF; #1; check("dump_l1k0_3ff", dump_data, 20'h00007);
        dump_sel = 3'd5; dump_addr = 12'h7FF; #1; check("dump_l2_7ff", dump_data, 20'hBEEF5);
        dump_sel = 3'd0; dump_addr = 12'h000; #1; check("dump_sel0", dump_data, 20'h00000);
        dump_sel = 3'd1; dump_addr = 12'h000; #1; check("dump_l0k0_0", dump_data, 20'h12345);
        dump_sel = 3'd3; dump_addr = 12'h400; #1; check("dump_oor", dump_data, 20'h00000);
        $display("dump checks done");

        // ---------------- busy falls -> done pulse ----------------
        busy = 1'b0;
        tick();
        check("done_pulse", done, 1'b1);
        tick();
        check("done_clear", done, 1'b0);
        check("idle_ready", ready, 1'b0);
        $display("done pulse observed");

        // ---------------- randomized run against the model ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        err_m = 1'b0;
        cnt_m = 0;
        check("start_clr_err", err, 1'b0);
        busy = 1'b1;
        tick();
        for (int c = 0; c < 300; c++) begin
            logic [2:0] s;
            cwr = 1'($urandom_range(0, 1));
            crd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) s = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'(6 + $urandom_range(0, 1));
            else s = 3'($urandom_range(1, 5));
            csel     = s;
            caddr_wr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 1023));
            caddr_rd = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 1023));
            cdata_wr = 20'($urandom);
            img_we   = ($urandom_range(0, 49) == 0);
            img_addr = 12'($urandom);
            img_wdata = 20'($urandom);
            iaddr     = 12'($urandom);
            dump_sel  = 3'($urandom_range(0, 7));
            dump_addr = 12'($urandom);
            #1;
            check("rnd_idata", idata, img_m[iaddr]);
            check("rnd_cdata_rd", cdata_rd, crd ? m_read(csel, caddr_rd) : 20'h0);
            check("rnd_dump", dump_data, m_read(dump_sel, dump_addr));
            model_step();
            tick();
            check("rnd_err", err, err_m);
            check("rnd_cnt", wr_count, 16'(cnt_m));
            $display("rnd %0d: cwr=%0b crd=%0b sel=%0d wa=%0h ra=%0h rd=%0h err=%0b cnt=%0d",
                     c, cwr, crd, csel, caddr_wr, caddr_rd, cdata_rd, err, wr_count);
        end
        cwr = 1'b0; crd = 1'b0; img_we = 1'b0;
        busy = 1'b0;
        tick();
        tick();

        // ---------------- start + img_we together, then timeout ----------------
        img_we = 1'b1; img_addr = 12'h041; img_wdata = 20'hFACE5; start = 1'b1;
        img_m[12'h041] = 20'hFACE5;
        tick();
        img_we = 1'b0; start = 1'b0;
        iaddr = 12'h041;
        #1;
        check("idle_img_we_start", idata, 20'hFACE5);
        check("timeout_err_clear", err, 1'b0);
        n = 0;
        while (ready && n < 40) begin
            n++;
            tick();
        end
        check("timeout_ready_cycles", 32'(n), 32'd16);
        check("timeout_err", err, 1'b1);
        check("timeout_ready_low", ready, 1'b0);
        $display("timeout: ready held %0d cycles, err=%0b", n, err);

        // ---------------- reset during RUN ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        busy = 1'b1;
        tick();
        cwr = 1'b1; csel = 3'd1; caddr_wr = 12'h010; cdata_wr = 20'h77777;
        tick();
        csel = 3'd0;
        tick();
        cwr = 1'b0;
        check("prerst_err", err, 1'b1);
        check("prerst_cnt", wr_count, 16'd1);
        busy = 1'b0;
        reset = 1'b1;
        tick();
        check("midrst_ready", ready, 1'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_cnt", wr_count, 16'd0);
        check("midrst_done", done, 1'b0);
        dump_sel = 3'd1; dump_addr = 12'h010;
        #1;
        check("midrst_retain", dump_data, 20'h77777);
        reset = 1'b0;
        $display("reset during run: ready=%0b err=%0b cnt=%0d", ready, err, wr_count);

        // ---------------- reset while ready is high ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_ready", ready, 1'b1);
        reset = 1'b1;
        tick();
        check("req_rst_ready", ready, 1'b0);
        reset = 1'b0;
        tick();
        check("req_rst_idle", ready, 1'b0);
        $display("reset during request: ready=%0b", ready);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
